// File: rtl/axi_slice_pkg.sv
// Shared AXI slice definitions: burst encodings and the splitter FSM states.
package axi_slice_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic {
      ST_IDLE,
      ST_SPLIT
   } split_state_e;

endpackage : axi_slice_pkg

// File: rtl/axi_ar_splitter.sv
// AXI read-address splitter: breaks long INCR bursts into sub-bursts of at
// most MAX_BEATS beats, presented through a single registered output slot.
module axi_ar_splitter
   import axi_slice_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int USER_WIDTH = 6,
   parameter int MAX_BEATS  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic                  slave_valid_i,
   output logic                  slave_ready_o,
   input  logic [ADDR_WIDTH-1:0] slave_addr_i,
   input  logic [3:0]            slave_prot_i,
   input  logic [3:0]            slave_region_i,
   input  logic [3:0]            slave_cache_i,
   input  logic [3:0]            slave_qos_i,
   input  logic [7:0]            slave_len_i,
   input  logic [2:0]            slave_size_i,
   input  logic [1:0]            slave_burst_i,
   input  logic                  slave_lock_i,
   input  logic [ID_WIDTH-1:0]   slave_id_i,
   input  logic [USER_WIDTH-1:0] slave_user_i,

   output logic                  master_valid_o,
   input  logic                  master_ready_i,
   output logic [ADDR_WIDTH-1:0] master_addr_o,
   output logic [3:0]            master_prot_o,
   output logic [3:0]            master_region_o,
   output logic [3:0]            master_cache_o,
   output logic [3:0]            master_qos_o,
   output logic [7:0]            master_len_o,
   output logic [2:0]            master_size_o,
   output logic [1:0]            master_burst_o,
   output logic                  master_lock_o,
   output logic [ID_WIDTH-1:0]   master_id_o,
   output logic [USER_WIDTH-1:0] master_user_o,
   output logic                  master_split_last_o
);

   localparam logic [8:0] MAX_BEATS_W = 9'(MAX_BEATS);
   localparam logic [7:0] MAX_LEN     = 8'(MAX_BEATS - 1);

   // Attributes copied unchanged to every sub-burst. The slot copy doubles as
   // the stored AR while splitting, so no second copy is kept.
   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [USER_WIDTH-1:0] user;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic                  lock;
      logic [3:0]            cache;
      logic [3:0]            prot;
      logic [3:0]            qos;
      logic [3:0]            region;
   } ar_attr_t;

   split_state_e          state_q, state_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [8:0]            remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   ar_attr_t              attr_q, attr_d;

   logic                  slot_free;
   logic                  slave_ready;
   logic [8:0]            burst_beats;
   ar_attr_t              slave_attr;

   // Byte distance covered by one full sub-burst of the given beat size.
   function automatic logic [ADDR_WIDTH-1:0] burst_step(input logic [2:0] size);
      return ADDR_WIDTH'(MAX_BEATS) << size;
   endfunction

   // Address rounded down to the beat-size boundary.
   function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0]            size);
      return addr & ~((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1));
   endfunction

   // Next-state and slot-load decisions for the IDLE/SPLIT FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
      state_d     = state_q;
      valid_d     = valid_q;
      last_d      = last_q;
      remaining_d = remaining_q;
      next_addr_d = next_addr_q;
      addr_d      = addr_q;
      len_d       = len_q;
      attr_d      = attr_q;

      slot_free   = !valid_q || master_ready_i;
      slave_ready = (state_q == ST_IDLE) && slot_free && !rst_i;
      burst_beats = {1'b0, slave_len_i} + 9'd1;
      slave_attr  = '{id: slave_id_i, user: slave_user_i, size: slave_size_i,
                      burst: slave_burst_i, lock: slave_lock_i, cache: slave_cache_i,
                      prot: slave_prot_i, qos: slave_qos_i, region: slave_region_i};

      // A consumed slot empties unless something is loaded below.
      if (slot_free) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (slave_valid_i && slave_ready) begin
               valid_d = 1'b1;
               attr_d  = slave_attr;
               addr_d  = slave_addr_i;
               if (slave_burst_i != BURST_INCR || burst_beats <= MAX_BEATS_W) begin
                  len_d  = slave_len_i;
                  last_d = 1'b1;
               end else begin
                  len_d       = MAX_LEN;
                  last_d      = 1'b0;
                  remaining_d = burst_beats - MAX_BEATS_W;
                  next_addr_d = align_addr(slave_addr_i, slave_size_i)
                                + burst_step(slave_size_i);
                  state_d     = ST_SPLIT;
               end
            end
         end
         ST_SPLIT: begin
            if (slot_free) begin
               valid_d = 1'b1;
               addr_d  = next_addr_q;
               if (remaining_q <= MAX_BEATS_W) begin
                  len_d   = 8'(remaining_q - 9'd1);
                  last_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  len_d       = MAX_LEN;
                  last_d      = 1'b0;
                  remaining_d = remaining_q - MAX_BEATS_W;
                  next_addr_d = next_addr_q + burst_step(attr_q.size);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state: FSM, slot valid, split-last flag and remaining beat count.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst_i) begin
         state_q     <= ST_IDLE;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         remaining_q <= remaining_d;
      end
   end

   // Slot payload and split address: qualified by valid/state, so unreset.
   always_ff @(posedge clk_i) begin
      // NOTE: data registers carry no reset; their contents are ignored until valid is set.
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      attr_q      <= attr_d;
   end

   assign slave_ready_o       = slave_ready;
   assign master_valid_o      = valid_q;
   assign master_split_last_o = last_q;
   assign master_addr_o       = addr_q;
   assign master_len_o        = len_q;
   assign master_id_o         = attr_q.id;
   assign master_user_o       = attr_q.user;
   assign master_size_o       = attr_q.size;
   assign master_burst_o      = attr_q.burst;
   assign master_lock_o       = attr_q.lock;
   assign master_cache_o      = attr_q.cache;
   assign master_prot_o       = attr_q.prot;
   assign master_qos_o        = attr_q.qos;
   assign master_region_o     = attr_q.region;

endmodule : axi_ar_splitter

// File: tb/tb_axi_ar_splitter.sv
// Bench for axi_ar_splitter: queue-based reference model of the expected
// sub-burst sequence, compared against the output slot every cycle.
module tb_axi_ar_splitter;

   localparam int MB = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        slave_valid_i;
   logic        slave_ready_o;
   logic [31:0] slave_addr_i;
   logic [3:0]  slave_prot_i, slave_region_i, slave_cache_i, slave_qos_i;
   logic [7:0]  slave_len_i;
   logic [2:0]  slave_size_i;
   logic [1:0]  slave_burst_i;
   logic        slave_lock_i;
   logic [3:0]  slave_id_i;
   logic [5:0]  slave_user_i;
   logic        master_valid_o;
   logic        master_ready_i;
   logic [31:0] master_addr_o;
   logic [3:0]  master_prot_o, master_region_o, master_cache_o, master_qos_o;
   logic [7:0]  master_len_o;
   logic [2:0]  master_size_o;
   logic [1:0]  master_burst_o;
   logic        master_lock_o;
   logic [3:0]  master_id_o;
   logic [5:0]  master_user_o;
   logic        master_split_last_o;

   axi_ar_splitter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .slave_valid_i(slave_valid_i), .slave_ready_o(slave_ready_o),
      .slave_addr_i(slave_addr_i), .slave_prot_i(slave_prot_i),
      .slave_region_i(slave_region_i), .slave_cache_i(slave_cache_i),
      .slave_qos_i(slave_qos_i), .slave_len_i(slave_len_i),
      .slave_size_i(slave_size_i), .slave_burst_i(slave_burst_i),
      .slave_lock_i(slave_lock_i), .slave_id_i(slave_id_i),
      .slave_user_i(slave_user_i),
      .master_valid_o(master_valid_o), .master_ready_i(master_ready_i),
      .master_addr_o(master_addr_o), .master_prot_o(master_prot_o),
      .master_region_o(master_region_o), .master_cache_o(master_cache_o),
      .master_qos_o(master_qos_o), .master_len_o(master_len_o),
      .master_size_o(master_size_o), .master_burst_o(master_burst_o),
      .master_lock_o(master_lock_o), .master_id_o(master_id_o),
      .master_user_o(master_user_o), .master_split_last_o(master_split_last_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        last;
      logic [31:0] attrs; // {id,user,size,burst,lock,cache,prot,qos,region}
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   ar_t exp_q[$];
   ar_t xq[$];
   int  n_cmp = 0;
   int  n_fail = 0;
   int  n_out = 0;
   bit  model_on = 0;
   bit  rdy_rand = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic over beat counts, one entry per sub-burst.
   function automatic void expand(input ar_t a);
      int unsigned total, rem, n;
      logic [31:0] step, nxt;
      ar_t s;
      xq.delete();
      total = int'(a.len) + 1;
      if (a.burst != 2'b01 || total <= MB) begin
         s = a; s.last = 1'b1;
         xq.push_back(s);
         return;
      end
      step = 32'(MB) << a.size;
      s = a; s.len = 8'(MB - 1); s.last = 1'b0;
      xq.push_back(s);
      nxt = (a.addr & ~((32'd1 << a.size) - 32'd1)) + step;
      rem = total - MB;
      while (rem > 0) begin
         n = (rem < MB) ? rem : MB;
         s = a; s.addr = nxt; s.len = 8'(n - 1); s.last = (rem <= MB);
         xq.push_back(s);
         rem -= n;
         nxt += step;
      end
   endfunction

   function automatic ar_t mk(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
      ar_t a;
      a.addr = addr; a.len = len; a.size = size; a.burst = burst; a.last = 1'b0;
      a.attrs = {4'h0, 6'h0, size, burst, 1'b0, 16'h0};
      return a;
   endfunction

   // Per-cycle comparison of the slot against the model, then model update.
   initial begin
      bit  out_hs, in_hs;
      ar_t cap, h;
      wait (model_on);
      forever begin
         @(negedge clk_i);
         check("master_valid", master_valid_o, exp_q.size() > 0);
         check("slave_ready", slave_ready_o,
               (exp_q.size() == (master_valid_o ? 1 : 0)) &&
               (!master_valid_o || master_ready_i) && !rst_i);
         if (master_valid_o && exp_q.size() > 0) begin
            h = exp_q[0];
            check("addr", master_addr_o, h.addr);
            check("len", master_len_o, h.len);
            check("split_last", master_split_last_o, h.last);
            check("attrs", {master_id_o, master_user_o, master_size_o, master_burst_o,
                            master_lock_o, master_cache_o, master_prot_o, master_qos_o,
                            master_region_o}, h.attrs);
         end
         out_hs = master_valid_o && master_ready_i;
         in_hs  = slave_valid_i && slave_ready_o;
         cap.addr  = slave_addr_i;
         cap.len   = slave_len_i;
         cap.size  = slave_size_i;
         cap.burst = slave_burst_i;
         cap.last  = 1'b0;
         cap.attrs = {slave_id_i, slave_user_i, slave_size_i, slave_burst_i, slave_lock_i,
                      slave_cache_i, slave_prot_i, slave_qos_i, slave_region_i};
         @(posedge clk_i);
         if (rst_i) begin
            exp_q.delete();
         end else begin
            if (out_hs && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               n_out++;
            end
            if (in_hs) begin
               expand(cap);
               foreach (xq[i]) exp_q.push_back(xq[i]);
            end
         end
      end
   end

   // Downstream ready: always high or randomly stalling.
   initial begin
      master_ready_i = 1'b1;
      forever begin
         @(posedge clk_i); #1;
         master_ready_i = rdy_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
      end
   end

   task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit rnd_attr);
      bit hs = 0;
      int cnt = 0;
      slave_valid_i = 1'b1;
      slave_addr_i = addr; slave_len_i = len; slave_size_i = size; slave_burst_i = burst;
      if (rnd_attr) begin
         {slave_id_i, slave_user_i, slave_lock_i} = 11'($urandom);
         {slave_cache_i, slave_prot_i, slave_qos_i, slave_region_i} = 16'($urandom);
      end else begin
         slave_id_i = '0; slave_user_i = '0; slave_lock_i = 1'b0;
         slave_cache_i = '0; slave_prot_i = '0; slave_qos_i = '0; slave_region_i = '0;
      end
      do begin
         @(negedge clk_i);
         hs = slave_ready_o;
         @(posedge clk_i); #1;
         cnt++;
      end while (!hs && cnt < 2000);
      if (!hs) check("accept_timeout", 0, 1);
      slave_valid_i = 1'b0;
   endtask

   task automatic drain();
      int cnt = 0;
      while ((exp_q.size() > 0 || master_valid_o) && cnt < 3000) begin
         @(posedge clk_i); #1;
         cnt++;
      end
      check("drain_timeout", cnt < 3000, 1);
   endtask

   initial begin
      int base, cnt;
      rst_i = 1'b1;
      slave_valid_i = 1'b0;
      slave_addr_i = '0; slave_len_i = '0; slave_size_i = '0; slave_burst_i = '0;
      slave_lock_i = '0; slave_id_i = '0; slave_user_i = '0;
      slave_prot_i = '0; slave_region_i = '0; slave_cache_i = '0; slave_qos_i = '0;

      // Pin the model with hand-computed sub-burst lists.
      expand(mk(32'h1000, 8'd39, 3'd2, 2'b01));
      check("pin028_n", xq.size(), 3);
      check("pin028_a0", {xq[0].addr, xq[0].len, 7'd0, xq[0].last}, {32'h1000, 8'd15, 8'h00});
      check("pin028_a1", {xq[1].addr, xq[1].len, 7'd0, xq[1].last}, {32'h1040, 8'd15, 8'h00});
      check("pin028_a2", {xq[2].addr, xq[2].len, 7'd0, xq[2].last}, {32'h1080, 8'd7, 8'h01});
      expand(mk(32'h1002, 8'd31, 3'd2, 2'b01));
      check("pin029_n", xq.size(), 2);
      check("pin029_a1", {xq[1].addr, xq[1].len, 7'd0, xq[1].last}, {32'h1040, 8'd15, 8'h01});
      expand(mk(32'hFFFF_FFC0, 8'd31, 3'd2, 2'b01));
      check("pin033_a1", xq[1].addr, 32'h0000_0000);
      expand(mk(32'h2000, 8'd200, 3'd3, 2'b00));
      check("pin030_fixed", {xq.size(), xq[0].len, 7'd0, xq[0].last}, {32'd1, 8'd200, 8'h01});

      repeat (2) @(posedge clk_i);
      model_on = 1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("reset_valid", master_valid_o, 0);
      check("reset_last", master_split_last_o, 0);

      // Directed bursts through the DUT.
      send_ar(32'h1000, 8'd39, 3'd2, 2'b01, 0);
      send_ar(32'h1002, 8'd31, 3'd2, 2'b01, 0);
      send_ar(32'h3000, 8'd15, 3'd2, 2'b10, 1);
      send_ar(32'h4004, 8'd200, 3'd2, 2'b00, 1);
      send_ar(32'h5000, 8'd15, 3'd1, 2'b01, 1);
      send_ar(32'hFFFF_FFC0, 8'd31, 3'd2, 2'b01, 0);
      drain();

      // Back-to-back short bursts: one accept per cycle.
      base = n_out;
      for (int i = 0; i < 8; i++) send_ar(32'h100 * i, 8'(i), 3'd2, 2'b01, 1);
      drain();
      check("b2b_count", n_out - base, 8);

      // Longest INCR burst under random back-pressure.
      rdy_rand = 1;
      base = n_out;
      send_ar(32'h8000_0000, 8'd255, 3'd2, 2'b01, 1);
      drain();
      check("len255_count", n_out - base, 16);

      // Random mix of bursts, sizes, lengths and attributes.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_i);
         #0;
         send_ar($urandom, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 1);
      end
      drain();
      rdy_rand = 0;

      // Reset after the second of four sub-bursts.
      base = n_out;
      send_ar(32'hA000, 8'd63, 3'd2, 2'b01, 1);
      cnt = 0;
      while (n_out < base + 2 && cnt < 200) begin
         @(posedge clk_i); #1;
         cnt++;
      end
      check("mid_split_reach", n_out - base, 2);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("mid_reset_valid", master_valid_o, 0);
      base = n_out;
      repeat (10) @(posedge clk_i);
      #1;
      check("mid_reset_no_more", n_out - base, 0);

      send_ar(32'h1000, 8'd39, 3'd2, 2'b01, 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_axi_ar_splitter

// File: doc/axi_ar_splitter.md
AXI_AR_SPLITTER -- requirements
Module: axi_ar_splitter

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AR ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter USER_WIDTH, default 6, AR user width.
REQ-004 SHALL have parameter MAX_BEATS, default 16, max beats per emitted sub-burst; power of two, 2..256.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port slave_valid_i  in  1  upstream AR valid.
REQ-007 SHALL have port slave_ready_o  out  1  upstream AR ready.
REQ-008 SHALL have port slave_addr_i  in  ADDR_WIDTH  AR address.
REQ-009 SHALL have ports slave_prot_i, slave_region_i, slave_cache_i, slave_qos_i  in  4 each  AR attributes.
REQ-010 SHALL have ports slave_len_i  in  8, slave_size_i  in  3, slave_burst_i  in  2, slave_lock_i  in  1  AR burst fields.
REQ-011 SHALL have ports slave_id_i  in  ID_WIDTH and slave_user_i  in  USER_WIDTH  AR ID and user.
REQ-012 SHALL have master_* outputs mirroring REQ-008..011 (same names, _o suffix), plus master_valid_o  out  1, master_ready_i  in  1.
REQ-013 SHALL have port master_split_last_o  out  1  high on the final (or only) sub-burst of an original AR.

Function
REQ-014 Output SHALL be a single registered slot; all master_* outputs held stable while master_valid_o=1 and master_ready_i=0.
REQ-015 Slot is free when master_valid_o=0 or master_ready_i=1 in the same cycle.
REQ-016 FSM SHALL have states IDLE and SPLIT.
REQ-017 IDLE: slave_ready_o SHALL equal slot-free; SPLIT: slave_ready_o SHALL be 0.
REQ-018 Accept (IDLE, slave_valid_i and slave_ready_o) with burst != INCR(01) or len+1 <= MAX_BEATS: load slot with fields unchanged, split_last=1, stay IDLE.
REQ-019 Accept otherwise: load slot with len=MAX_BEATS-1, original addr, split_last=0; store remaining=len+1-MAX_BEATS (9-bit), next_addr=(addr with low size bits cleared)+(MAX_BEATS<<size); go SPLIT.
REQ-020 SPLIT, slot free: load len=min(remaining,MAX_BEATS)-1, addr=next_addr, other fields from stored AR; split_last=1 and go IDLE when remaining<=MAX_BEATS, else split_last=0, remaining-=MAX_BEATS, next_addr+=MAX_BEATS<<size.
REQ-021 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; id, user, size, burst, lock, cache, prot, qos, region SHALL be copied unchanged to every sub-burst.
REQ-022 Latency SHALL be one cycle from accept to master_valid_o; back-to-back accepts SHALL sustain one AR per cycle with master_ready_i=1.
REQ-023 A new AR SHALL NOT be accepted in the cycle the last sub-burst is loaded.

Reset
REQ-024 rst_i SHALL clear master_valid_o, master_split_last_o, remaining, and state to IDLE; other data registers need not reset.
REQ-025 slave_ready_o SHALL be 0 while rst_i=1; reset mid-SPLIT SHALL discard remaining sub-bursts.

Structure
REQ-026 Burst encodings (FIXED/INCR/WRAP) and the FSM state enum SHALL live in shared package axi_slice_pkg.
REQ-027 No sub-module; the design SHALL sit directly upstream of the AR FIFO buffer stage, driving its slave side.

Verification
REQ-028 INCR addr 0x1000 size 2 len 39, MAX_BEATS 16 -> three ARs: (0x1000,len15,last0),(0x1040,len15,last0),(0x1080,len7,last1).
REQ-029 INCR addr 0x1002 size 2 len 31 -> (0x1002,len15,last0),(0x1040,len15,last1).
REQ-030 WRAP len 15 and FIXED len 200 -> each one unchanged AR, last=1; INCR len 15 -> one AR, last=1.
REQ-031 INCR len 255 with master_ready_i toggling randomly -> 16 ARs of len 15, addresses step MAX_BEATS<<size, outputs stable under stall, slave_ready_o=0 throughout.
REQ-032 rst_i asserted after second of four sub-bursts -> next cycle master_valid_o=0, state IDLE, no further sub-bursts emitted.
REQ-033 Address 0xFFFFFFC0 size 2 len 31 -> second AR addr 0x00000000 (wrap).
